// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and a
// small decode helper used by the sequencer.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_3    = 2'd3
  } state_t;

  // The unused encoding S_3 behaves exactly like IDLE, so it can also accept.
  function automatic logic is_ready(input state_t s);
    return (s != S_RUN);
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell; the serial adder feeds it one operand bit
// pair per cycle together with the registered carry.
module serial_adder_full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);

  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: sums two WIDTH-bit operands LSB-first over WIDTH cycles
// through one full adder cell and a registered carry loop.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  // The partial-result register only needs the upper WIDTH-1 bits; the
  // newest bit comes straight from the adder on the final edge.
  localparam int RW = (WIDTH > 1) ? WIDTH - 1 : 1;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [RW-1:0]      r_res;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;

  logic               w_s;
  logic               w_c;
  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_res_shift;
  logic [RW-1:0]      w_res_keep;

  serial_adder_full_adder u_fa (
    .i_a (r_a_sh[0]),
    .i_b (r_b_sh[0]),
    .i_c (r_carry),
    .o_s (w_s),
    .o_c (w_c)
  );

  generate
    if (WIDTH == 1) begin : g_res_w1
      assign w_res_shift = w_s;
      assign w_res_keep  = '0;
    end else begin : g_res_wn
      assign w_res_shift = {w_s, r_res};
      assign w_res_keep  = w_res_shift[WIDTH-1:1];
    end
  endgenerate

  always_comb begin
    w_accept     = is_ready(r_state) && start;
    w_last       = (r_state == S_RUN) && (r_cnt == CNT_W'(WIDTH - 1));
    w_state_next = S_IDLE;
    case (r_state)
      S_RUN:   w_state_next = w_last ? S_DONE : S_RUN;
      default: w_state_next = start ? S_RUN : S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_res   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == S_RUN);
      r_done  <= (w_state_next == S_DONE);
      if (w_accept) begin
        r_a_sh  <= a;
        r_b_sh  <= b;
        r_carry <= c_in;
        r_cnt   <= '0;
      end else if (r_state == S_RUN) begin
        r_a_sh  <= r_a_sh >> 1;
        r_b_sh  <= r_b_sh >> 1;
        r_carry <= w_c;
        r_res   <= w_res_keep;
        r_cnt   <= r_cnt + 1'b1;
        // Outputs only ever see the completed word, never a partial one.
        if (w_last) begin
          r_sum  <= w_res_shift;
          r_cout <= w_c;
        end
      end
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign sum   = r_sum;
  assign c_out = r_cout;

endmodule
